// File: rtl/warp_scheduler.sv
// Warp context store with IDLE/RUN/SWITCH scheduling and round-robin selection over ready warps.
// Launch reaches RUN two edges later; a yield or RET costs one bubble cycle; no backpressure, bad launches flagged on launch_err.
module warp_scheduler #(
    parameter int NUM_WARPS         = 4,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    localparam int WID_BITS         = $clog2(NUM_WARPS),
    localparam int TC_BITS          = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 launch_valid,
    input  logic [WID_BITS-1:0]  launch_warp,
    input  logic [PC_BITS-1:0]   launch_pc,
    input  logic [TC_BITS-1:0]   launch_thread_count,
    input  logic                 wb_valid,
    input  logic [PC_BITS-1:0]   wb_pc,
    input  logic [2:0]           wb_state,
    input  logic                 wb_done,
    input  logic                 wb_yield,
    input  logic                 wb_stall,
    input  logic [NUM_WARPS-1:0] wake,
    input  logic                 flush,
    output logic                 active_valid,
    output logic [WID_BITS-1:0]  active_warp,
    output logic [PC_BITS-1:0]   active_pc,
    output logic [2:0]           active_state,
    output logic [TC_BITS-1:0]   active_thread_count,
    output logic                 launch_err,
    output logic                 all_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SWITCH = 2'd2
    } fsm_t;

    fsm_t                 r_fsm;
    fsm_t                 w_fsm_nxt;
    logic                 w_enter;

    logic [NUM_WARPS-1:0] r_valid;
    logic [NUM_WARPS-1:0] r_done;
    logic [NUM_WARPS-1:0] r_stalled;
    logic [PC_BITS-1:0]   r_pc    [NUM_WARPS];
    logic [2:0]           r_state [NUM_WARPS];
    logic [TC_BITS-1:0]   r_tc    [NUM_WARPS];

    logic [NUM_WARPS-1:0] w_valid_nxt;
    logic [NUM_WARPS-1:0] w_done_nxt;
    logic [NUM_WARPS-1:0] w_stalled_nxt;
    logic [NUM_WARPS-1:0] w_ready;
    logic                 w_all_done_nxt;

    logic [WID_BITS-1:0]  r_rr;
    logic [WID_BITS-1:0]  w_win;
    logic                 w_found;

    logic                 r_active_valid;
    logic [WID_BITS-1:0]  r_active_warp;
    logic [PC_BITS-1:0]   r_active_pc;
    logic [2:0]           r_active_state;
    logic [TC_BITS-1:0]   r_active_tc;
    logic                 r_launch_err;
    logic                 r_all_done;

    logic                 w_wb;
    logic                 w_wb_done;
    logic                 w_wb_yield;
    logic                 w_stall_set;
    logic                 w_launch_rej;
    logic                 w_launch_ok;

    assign w_ready      = r_valid & ~r_done & ~r_stalled;

    assign w_wb         = (r_fsm == S_RUN) & wb_valid & ~flush;
    assign w_wb_done    = w_wb & wb_done;
    assign w_wb_yield   = w_wb & wb_yield & ~wb_done;
    assign w_stall_set  = w_wb_yield & wb_stall;

    assign w_launch_rej = launch_valid & ~flush & r_valid[launch_warp] & ~r_done[launch_warp];
    assign w_launch_ok  = launch_valid & ~flush & ~w_launch_rej;

    // r_rr always equals the active warp once a warp has run, so one search
    // from r_rr+1 serves both IDLE and SWITCH; offset NUM_WARPS wraps to r_rr itself.
    always_comb begin
        logic [WID_BITS-1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_win   = r_rr;
        for (int k = NUM_WARPS; k >= 1; k--) begin
            v_idx = r_rr + WID_BITS'(k);
            if (w_ready[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_enter   = 1'b0;
        if (flush) begin
            w_fsm_nxt = S_IDLE;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_found) begin
                        w_fsm_nxt = S_RUN;
                        w_enter   = 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_wb_done || w_wb_yield) begin
                        w_fsm_nxt = S_SWITCH;
                    end
                end
                S_SWITCH: begin
                    if (w_found) begin
                        w_fsm_nxt = S_RUN;
                        w_enter   = 1'b1;
                    end else begin
                        w_fsm_nxt = S_IDLE;
                    end
                end
                default: w_fsm_nxt = S_IDLE;
            endcase
        end
    end

    // Wake is applied after stall-set so a same-cycle wake leaves the slot runnable.
    always_comb begin
        w_valid_nxt   = r_valid;
        w_done_nxt    = r_done;
        w_stalled_nxt = r_stalled;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (w_wb_done && (r_active_warp == WID_BITS'(i))) begin
                w_done_nxt[i] = 1'b1;
            end
            if (w_stall_set && (r_active_warp == WID_BITS'(i))) begin
                w_stalled_nxt[i] = 1'b1;
            end
            if (wake[i]) begin
                w_stalled_nxt[i] = 1'b0;
            end
            if (w_launch_ok && (launch_warp == WID_BITS'(i))) begin
                w_valid_nxt[i]   = 1'b1;
                w_done_nxt[i]    = 1'b0;
                w_stalled_nxt[i] = 1'b0;
            end
        end
        if (flush) begin
            w_valid_nxt   = '0;
            w_done_nxt    = '0;
            w_stalled_nxt = '0;
        end
    end

    assign w_all_done_nxt = (|w_valid_nxt) && ((w_valid_nxt & ~w_done_nxt) == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_pc[i]    <= '0;
                r_state[i] <= '0;
                r_tc[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (w_launch_ok && (launch_warp == WID_BITS'(i))) begin
                    r_pc[i]    <= launch_pc;
                    r_state[i] <= 3'b000;
                    r_tc[i]    <= launch_thread_count;
                end else if (w_wb && (r_active_warp == WID_BITS'(i))) begin
                    r_pc[i]    <= wb_pc;
                    r_state[i] <= wb_state;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm          <= S_IDLE;
            r_valid        <= '0;
            r_done         <= '0;
            r_stalled      <= '0;
            r_rr           <= WID_BITS'(NUM_WARPS - 1);
            r_active_valid <= 1'b0;
            r_active_warp  <= '0;
            r_active_pc    <= '0;
            r_active_state <= '0;
            r_active_tc    <= '0;
            r_launch_err   <= 1'b0;
            r_all_done     <= 1'b0;
        end else begin
            r_fsm          <= w_fsm_nxt;
            r_valid        <= w_valid_nxt;
            r_done         <= w_done_nxt;
            r_stalled      <= w_stalled_nxt;
            r_active_valid <= (w_fsm_nxt == S_RUN);
            r_launch_err   <= w_launch_rej;
            r_all_done     <= w_all_done_nxt;
            if (w_enter) begin
                r_rr           <= w_win;
                r_active_warp  <= w_win;
                r_active_pc    <= r_pc[w_win];
                r_active_state <= r_state[w_win];
                r_active_tc    <= r_tc[w_win];
            end else if (w_wb) begin
                // Keep the active view in step with the slot it mirrors.
                r_active_pc    <= wb_pc;
                r_active_state <= wb_state;
            end
        end
    end

    assign active_valid        = r_active_valid;
    assign active_warp         = r_active_warp;
    assign active_pc           = r_active_pc;
    assign active_state        = r_active_state;
    assign active_thread_count = r_active_tc;
    assign launch_err          = r_launch_err;
    assign all_done            = r_all_done;

endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 Parameter NUM_WARPS, default 4: number of warp contexts held; power of two, 2..16.
REQ-002 Parameter THREADS_PER_BLOCK, default 4: threads per warp; TC_BITS = $clog2(THREADS_PER_BLOCK)+1.
REQ-003 Parameter PC_BITS, default 8: program counter width.
REQ-004 Port list, one per line, SHALL be exactly as follows; WID_BITS = $clog2(NUM_WARPS):
- clk  in  1  single clock; all state rises on posedge.
- reset  in  1  asynchronous, active-low reset.
- launch_valid  in  1  load a warp context this cycle.
- launch_warp  in  WID_BITS  target warp slot.
- launch_pc  in  PC_BITS  start PC.
- launch_thread_count  in  TC_BITS  active threads in warp.
- wb_valid  in  1  core writes back the active warp's context.
- wb_pc  in  PC_BITS  next PC of the active warp.
- wb_state  in  3  core_state to save.
- wb_done  in  1  active warp executed RET.
- wb_yield  in  1  active warp gives up the core.
- wb_stall  in  1  with yield: warp waits on memory.
- wake  in  NUM_WARPS  per-warp memory-complete strobe.
- flush  in  1  synchronous clear of all contexts.
- active_valid  out  1  core may issue from active warp.
- active_warp  out  WID_BITS  active warp id.
- active_pc  out  PC_BITS  saved PC of active warp.
- active_state  out  3  saved core_state of active warp.
- active_thread_count  out  TC_BITS  thread count of active warp.
- launch_err  out  1  one-cycle pulse: launch rejected.
- all_done  out  1  every launched warp has finished.

Function
REQ-005 Each slot SHALL hold: valid, done, stalled, pc, state, thread_count; ready = valid & !done & !stalled.
REQ-006 FSM states SHALL be IDLE, RUN, SWITCH.
REQ-007 IDLE: if any slot ready, next cycle RUN with round-robin winner; otherwise stay IDLE.
REQ-008 RUN: active_valid=1; wb_valid SHALL write wb_pc/wb_state into the active slot on the same edge.
REQ-009 RUN with wb_valid&wb_done: set done, go SWITCH; wb_yield is ignored.
REQ-010 RUN with wb_valid&wb_yield&!wb_done: save context, set stalled iff wb_stall, go SWITCH.
REQ-011 SWITCH: active_valid=0 (exactly one bubble cycle); pick next ready slot searching from active_warp+1 with wrap-around modulo NUM_WARPS; the yielding warp itself is eligible last; none ready -> IDLE.
REQ-012 Arbiter SHALL be combinational over ready bits; the RR pointer SHALL update only when a warp enters RUN.
REQ-013 active_* SHALL be registered and reflect the selected slot from the first RUN cycle.
REQ-014 Launch to a slot with valid&!done SHALL be rejected: launch_err=1 next cycle, no state change.
REQ-015 Accepted launch SHALL set valid=1, done=0, stalled=0, load pc/thread_count, state=3'b000.
REQ-016 wake[i] SHALL clear stalled[i]; wake and stall-set to the same slot in the same cycle -> slot not stalled.
REQ-017 Launch and writeback to different slots in one cycle SHALL both take effect.
REQ-018 all_done SHALL be 1 iff at least one slot is valid and every valid slot is done; registered.
REQ-019 flush SHALL clear all valid/done/stalled bits, force IDLE and active_valid=0 next cycle; flush overrides launch, wb and wake.
REQ-020 wb_valid outside RUN SHALL be ignored.

Reset
REQ-021 reset low SHALL immediately clear all slots, FSM=IDLE, active_valid=0, active_warp=0, active_pc=0, active_state=0, active_thread_count=0, launch_err=0, all_done=0, RR pointer=NUM_WARPS-1 (warp 0 wins first).
REQ-022 Reset assertion mid-RUN SHALL discard all contexts; no writeback occurs on the reset edge.

Verification
REQ-023 Launch w0 pc=0x10, w1 pc=0x20 -> RUN w0, active_pc=0x10; yield without stall -> 1 bubble, RUN w1, active_pc=0x20.
REQ-024 w1 yield wb_stall=1 with wb_pc=0x24, w0 done -> IDLE; wake[1] -> RUN w1, active_pc=0x24.
REQ-025 4 warps ready, each yields once -> order 0,1,2,3,0; w3 to w0 wrap verified.
REQ-026 Relaunch of running w2 -> launch_err pulse 1 cycle, w2 context unchanged.
REQ-027 All launched warps wb_done -> all_done=1 and IDLE; flush -> all_done=0 next cycle.
REQ-028 Assert reset during RUN -> all outputs zero asynchronously; after release the launched-before warps are gone.
